// File: rtl/lsu_ctrl.sv
// Load/store initiator: checks mode/range, issues aligned accesses natively and
// splits misaligned half/word accesses into sequential byte accesses.
module lsu_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int MEM_BYTES = 128,
    parameter bit SPLIT_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_mode,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_ra,
    output logic [2:0]        mem_rm,
    input  logic [31:0]       mem_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [2:0]        mem_wm,
    output logic [31:0]       mem_wd
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [ADDR_W:0] LP_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t            r_state, w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_mode;
    logic [31:0]       r_wdata;
    logic [1:0]        r_szm1;
    logic              r_split;
    logic [1:0]        r_idx;
    logic [31:0]       r_data;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [1:0]        w_szm1;
    logic              w_illegal;
    logic [ADDR_W:0]   w_end;
    logic              w_range;
    logic              w_mis;
    logic              w_err;
    logic              w_last;
    logic [ADDR_W-1:0] w_cur;
    logic [31:0]       w_merge;
    logic [31:0]       w_ext;
    logic [31:0]       w_load_res;

    // Request decode; the range sum is one bit wider so it cannot wrap.
    always_comb begin
        case (req_mode[1:0])
            2'b00:   w_szm1 = 2'd0;
            2'b01:   w_szm1 = 2'd1;
            default: w_szm1 = 2'd3;
        endcase
    end

    assign w_illegal = (req_mode == 3'b011) || (req_mode[2:1] == 2'b11) ||
                       (req_mode[2] && req_we);
    assign w_end     = {1'b0, req_addr} + (ADDR_W+1)'(w_szm1);
    assign w_range   = (w_end >= LP_LIMIT);
    assign w_mis     = |(req_addr[1:0] & w_szm1);
    assign w_err     = w_illegal || w_range || (w_mis && !SPLIT_EN);

    assign w_last = r_split ? (r_idx == r_szm1) : 1'b1;
    assign w_cur  = r_addr + ADDR_W'(r_idx);

    always_comb begin
        w_merge = r_data;
        w_merge[{r_idx, 3'b000} +: 8] = mem_rd[7:0];
    end

    // Split loads arrive as raw bytes; only halfwords need explicit extension.
    always_comb begin
        w_ext = w_merge;
        if (r_szm1 == 2'd1)
            w_ext = r_mode[2] ? {16'h0, w_merge[15:0]} : {{16{w_merge[15]}}, w_merge[15:0]};
    end

    assign w_load_res = r_split ? w_ext : mem_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_ra     = '0;
        mem_wa     = '0;
        mem_rm     = 3'b111;
        mem_wm     = 3'b111;
        mem_wd     = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = w_err ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                mem_ra = w_cur;
                mem_wa = w_cur;
                if (r_we) begin
                    mem_we = 1'b1;
                    mem_wm = r_split ? 3'b000 : r_mode;
                    mem_wd = r_split ? {24'h0, r_wdata[{r_idx, 3'b000} +: 8]} : r_wdata;
                end else begin
                    mem_rm = r_split ? 3'b100 : r_mode;
                end
                if (w_last) w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_mode  <= 3'b000;
            r_wdata <= '0;
            r_szm1  <= 2'd0;
            r_split <= 1'b0;
            r_idx   <= 2'd0;
            r_data  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_addr  <= req_addr;
                    r_mode  <= req_mode;
                    r_wdata <= req_wdata;
                    r_szm1  <= w_szm1;
                    r_split <= w_mis;
                    r_idx   <= 2'd0;
                    r_data  <= '0;
                    if (w_err) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (!w_last) begin
                        r_data <= w_merge;
                        r_idx  <= r_idx + 2'd1;
                    end else begin
                        r_rdata <= r_we ? 32'h0 : w_load_res;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the core's data path and the byte-addressed data memory. The memory has combinational read ports and a synchronous write port; it accepts access modes 000/001/010 (signed b/h/w) and 100/101 (unsigned b/h).
- Accepts one load or store per valid/ready handshake.
- Checks mode legality and address range.
- Issues aligned accesses natively. Splits misaligned halfword/word accesses into sequential byte accesses, then merges and extends load data before returning a one-cycle response.

Parameters:
- ADDR_W, 9, byte-address width (matches memory ports).
- MEM_BYTES, 128, number of implemented memory bytes; any accessed byte at or above this is out of range.
- SPLIT_EN, 1, 1 = split misaligned accesses into bytes; 0 = flag misaligned accesses as errors.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_mode  in  3  load modes 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store modes 000 sb, 001 sh, 010 sw.
- req_wdata  in  32  store data; low bytes used.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  illegal mode, out of range, or misaligned with SPLIT_EN=0.
- mem_ra  out  ADDR_W  memory read address.
- mem_rm  out  3  memory read mode.
- mem_rd  in  32  memory read data, combinational from mem_ra/mem_rm.
- mem_we  out  1  memory write enable.
- mem_wa  out  ADDR_W  memory write address.
- mem_wm  out  3  memory write mode.
- mem_wd  out  32  memory write data.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async, any state) forces IDLE immediately. Outputs in reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_ra=0, mem_wa=0, mem_rm=111, mem_wm=111, mem_wd=0.
- Reset during a split store: state returns to IDLE. Bytes already written stay written; there is no rollback.
- In IDLE with req_valid=1: request is accepted on the clock edge and req_we, req_addr, req_mode and req_wdata are captured.
  - Size: 1 for modes 000/100, 2 for 001/101, 4 for 010.
- Error checks at accept, in order:
  - Illegal mode: 011, 110, 111; also 100/101 with req_we=1.
  - Range: addr+size-1 >= MEM_BYTES, computed at ADDR_W+1 bits so there is no wrap.
  - Misalignment with SPLIT_EN=0.
  - Any error goes directly to RESP with resp_err=1 and resp_rdata=0. No memory access and mem_we is never asserted.
- Aligned access (addr mod size == 0) takes 1 ACCESS cycle in the native mode.
  - Load: mem_ra=addr, mem_rm=mode; mem_rd is registered at the end of the cycle.
  - Store: mem_we=1, mem_wa=addr, mem_wm=mode, mem_wd=wdata.
- Misaligned access takes `size` ACCESS cycles, one per byte k = 0..size-1, at address addr+k.
  - Load: mem_rm=100; byte k is taken from mem_rd[7:0] and placed in result byte k.
  - Store: mem_wm=000, mem_wd[7:0]=wdata byte k, mem_we=1.
  - After the last byte the load result is sign-extended (modes 001, 010) or zero-extended (101) from size*8 bits.
- Outside ACCESS: mem_we=0, mem_rm=111, mem_wm=111.
- RESP lasts exactly 1 cycle: resp_valid=1 with final resp_rdata/resp_err, then IDLE. resp_rdata and resp_err hold their values until the next RESP; resp_valid is 0 elsewhere.
- Latency, with acceptance at edge E0:
  - Aligned or byte access: resp_valid high in the cycle after E1 (2 cycles).
  - Misaligned halfword: 3 cycles. Misaligned word: 5 cycles.
  - Error: 1 cycle.
- req_ready=0 in ACCESS and RESP. req_valid is ignored there and the inputs may change freely.
- A request presented in the same cycle as resp_valid is accepted one cycle later, in IDLE.
- No outstanding-request overlap.

Test Plan:
- Aligned lw: memory bytes 0x10..0x13 = 78 56 34 12, lw 0x10 → 1 ACCESS cycle with mem_rm=010; resp_valid 2 cycles after accept; rdata=0x12345678, err=0.
- Misaligned lh: bytes 0x03=0x34, 0x04=0xF2, lh 0x03 → 2 byte reads at 0x03 and 0x04 with rm=100; rdata=0xFFFFF234. Same access as lhu → 0x0000F234.
- Misaligned sw: sw 0x7B with wdata=0xAABBCCDD → mem_we pulses at 0x7B/0x7C/0x7D/0x7E with DD/CC/BB/AA and wm=000; then lw 0x7B returns 0xAABBCCDD.
- Range and illegal checks:
  - lw 0x7E → err=1, rdata=0, 1-cycle latency, mem_we never asserted.
  - Mode 011 → err=1.
  - Store with mode 100 → err=1.
- Reset mid split store: sw 0x41 with 0x11223344, assert reset after the 2nd byte write → outputs return to reset values immediately; bytes 0x41=44 and 0x42=33 written, 0x43 and 0x44 unchanged; req_ready=1.
- SPLIT_EN=0 build: lh 0x01 → err=1, no memory access. Back-to-back sb requests with req_valid held high → one accept per 3 cycles.
